dram_controller_mb: RTL and testbench

//  Parametrised multi-bank asynchronous-DRAM controller; successor to the single-bank CSn/RWn controller.

---
 rtl/dram_ctrl_pkg.sv | 38 +++
 rtl/dram_refresh_sched.sv | 41 ++++
 rtl/dram_controller_mb.sv | 264 ++++++++++++++++++++++++++
 tb/tb_dram_controller_mb.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_ctrl_pkg.sv
// Shared types and constants for the multi-bank FPM DRAM controller:
// FSM state encoding, config register indices and field widths.
package dram_ctrl_pkg;

    localparam int TW     = 8;
    localparam int RINT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ACT,
        S_CAS_ON,
        S_CAS_OFF,
        S_REF_RAS,
        S_REF_PRE
    } state_t;

    localparam logic [3:0] CFG_RINT_LO = 4'd0;
    localparam logic [3:0] CFG_RINT_HI = 4'd1;
    localparam logic [3:0] CFG_MODE    = 4'd2;
    localparam logic [3:0] CFG_T_RAS   = 4'd3;
    localparam logic [3:0] CFG_T_CAS   = 4'd4;
    localparam logic [3:0] CFG_T_RCD   = 4'd5;
    localparam logic [3:0] CFG_T_RP    = 4'd6;
    localparam logic [3:0] CFG_T_CP    = 4'd7;
    localparam logic [3:0] CFG_DONE    = 4'd8;

    // Column width is col_bits+1, never wider than the DRAM address bus.
    function automatic logic [4:0] clamp_cb(input logic [3:0] col_bits, input int unsigned lim);
        logic [4:0] w;
        w = {1'b0, col_bits} + 5'd1;
        if (32'(w) > lim) begin
            w = lim[4:0];
        end
        return w;
    endfunction

endpackage

// File: rtl/dram_refresh_sched.sv
// Refresh scheduler: interval timer, pending flag and refresh row counter.
// The timer runs only while enabled and no refresh is pending; done restarts it.
module dram_refresh_sched
    import dram_ctrl_pkg::*;
#(
    parameter int DA_W = 9
)(
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              done,
    input  logic [RINT_W-1:0] interval,
    output logic              refresh_pend,
    output logic [DA_W-1:0]   row_cnt
);

    logic [RINT_W-1:0] timer_reg;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            timer_reg    <= '0;
            refresh_pend <= 1'b0;
            row_cnt      <= '0;
        end else if (done) begin
            timer_reg    <= '0;
            refresh_pend <= 1'b0;
            row_cnt      <= row_cnt + DA_W'(1);
        end else if (enable && !refresh_pend) begin
            // >= also recovers if the interval is lowered below a running timer
            if (timer_reg >= interval) begin
                refresh_pend <= 1'b1;
            end else begin
                timer_reg <= timer_reg + RINT_W'(1);
                if (timer_reg + RINT_W'(1) == interval) begin
                    refresh_pend <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dram_controller_mb.sv
// Multi-bank FPM DRAM controller with per-bank open-row tracking and a byte-wide config port.
// Define DRAM_CBR_REFRESH_EN for CAS-before-RAS refresh; otherwise RAS-only refresh is used.
module dram_controller_mb
    import dram_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 20,
    parameter int DA_W     = 9,
    parameter int BANK_W   = 1,
    parameter int RINT_RST = 390
)(
    input  logic                   clk_i,
    input  logic                   rst_n,
    input  logic                   cfg_we,
    input  logic [3:0]             cfg_idx,
    input  logic [7:0]             cfg_data,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_W-1:0]      req_addr,
    output logic                   wr_le,
    output logic                   rd_le,
    output logic                   refresh_pend,
    output logic [DA_W-1:0]        dram_a,
    output logic [2**BANK_W-1:0]   dram_ras_n,
    output logic                   dram_cas_n,
    output logic                   dram_we_n,
    output logic                   dram_oe_n
);

    localparam int NUM_BANKS = 2**BANK_W;

`ifdef DRAM_CBR_REFRESH_EN
    localparam logic CBR = 1'b1;
`else
    localparam logic CBR = 1'b0;
`endif

    state_t              state_reg;
    logic [TW-1:0]       cnt_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic                we_reg;
    logic                ref_mode_reg;
    logic                cbr_wait_reg;
    logic [NUM_BANKS-1:0] open_valid;
    logic [DA_W-1:0]     open_row [NUM_BANKS];

    logic [RINT_W-1:0]   rint_reg;
    logic [3:0]          col_bits_reg;
    logic                page_en_reg;
    logic [TW-1:0]       t_ras_reg, t_cas_reg, t_rcd_reg, t_rp_reg, t_cp_reg;
    logic                cfg_done_reg;

    logic [DA_W-1:0]     row_cnt;
    logic                ref_done;
    logic                accept;
    logic                page_hit;
    logic [4:0]          cb;
    logic [BANK_W-1:0]   req_bank, cur_bank;
    logic [DA_W-1:0]     req_row, req_col, cur_row, cur_col;

    function automatic logic [DA_W-1:0] addr_col(input logic [ADDR_W-1:0] a, input logic [4:0] w);
        logic [ADDR_W-1:0] mask;
        mask = (ADDR_W'(1) << w) - ADDR_W'(1);
        return DA_W'(a & mask);
    endfunction

    function automatic logic [DA_W-1:0] addr_row(input logic [ADDR_W-BANK_W-1:0] nb, input logic [4:0] w);
        return DA_W'(nb >> w);
    endfunction

    assign cb       = clamp_cb(col_bits_reg, DA_W);
    assign req_bank = req_addr[ADDR_W-1 -: BANK_W];
    assign req_row  = addr_row(req_addr[ADDR_W-BANK_W-1:0], cb);
    assign req_col  = addr_col(req_addr, cb);
    assign cur_bank = addr_reg[ADDR_W-1 -: BANK_W];
    assign cur_row  = addr_row(addr_reg[ADDR_W-BANK_W-1:0], cb);
    assign cur_col  = addr_col(addr_reg, cb);

    assign req_ready = cfg_done_reg && (state_reg == S_IDLE) && !refresh_pend;
    assign accept    = req_valid && req_ready;
    assign wr_le     = accept && req_we;
    assign page_hit  = page_en_reg && open_valid[req_bank] && (open_row[req_bank] == req_row);
    assign ref_done  = (state_reg == S_REF_PRE) && (cnt_reg == '0);

    dram_refresh_sched #(
        .DA_W(DA_W)
    ) u_sched (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .enable      (cfg_done_reg),
        .done        (ref_done),
        .interval    (rint_reg),
        .refresh_pend(refresh_pend),
        .row_cnt     (row_cnt)
    );

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            addr_reg     <= '0;
            we_reg       <= 1'b0;
            ref_mode_reg <= 1'b0;
            cbr_wait_reg <= 1'b0;
            open_valid   <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                open_row[b] <= '0;
            end
            rint_reg     <= RINT_W'(RINT_RST);
            col_bits_reg <= 4'd7;
            page_en_reg  <= 1'b0;
            t_ras_reg    <= '0;
            t_cas_reg    <= '0;
            t_rcd_reg    <= '0;
            t_rp_reg     <= '0;
            t_cp_reg     <= '0;
            cfg_done_reg <= 1'b0;
            dram_a       <= '1;
            dram_ras_n   <= '1;
            dram_cas_n   <= 1'b1;
            dram_we_n    <= 1'b1;
            dram_oe_n    <= 1'b1;
            rd_le        <= 1'b0;
        end else begin
            rd_le <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (cfg_we) begin
                        case (cfg_idx)
                            CFG_RINT_LO: rint_reg[7:0]  <= cfg_data;
                            CFG_RINT_HI: rint_reg[15:8] <= cfg_data;
                            CFG_MODE: begin
                                page_en_reg  <= cfg_data[4];
                                col_bits_reg <= cfg_data[3:0];
                            end
                            CFG_T_RAS:   t_ras_reg    <= cfg_data;
                            CFG_T_CAS:   t_cas_reg    <= cfg_data;
                            CFG_T_RCD:   t_rcd_reg    <= cfg_data;
                            CFG_T_RP:    t_rp_reg     <= cfg_data;
                            CFG_T_CP:    t_cp_reg     <= cfg_data;
                            CFG_DONE:    cfg_done_reg <= cfg_data[0];
                            default: ;
                        endcase
                    end
                    if (refresh_pend) begin
                        if (|open_valid) begin
                            state_reg    <= S_PRE;
                            cnt_reg      <= t_rp_reg;
                            ref_mode_reg <= 1'b1;
                            dram_ras_n   <= '1;
                        end else begin
                            state_reg    <= S_REF_RAS;
                            cnt_reg      <= t_ras_reg;
                            cbr_wait_reg <= CBR;
                            dram_ras_n   <= {NUM_BANKS{CBR}};
                            dram_cas_n   <= ~CBR;
                            dram_a       <= CBR ? {DA_W{1'b1}} : row_cnt;
                        end
                    end else if (accept) begin
                        addr_reg     <= req_addr;
                        we_reg       <= req_we;
                        ref_mode_reg <= 1'b0;
                        dram_oe_n    <= 1'b0;
                        if (page_hit) begin
                            state_reg  <= S_CAS_ON;
                            cnt_reg    <= t_cas_reg;
                            dram_cas_n <= 1'b0;
                            dram_a     <= req_col;
                            dram_we_n  <= ~req_we;
                        end else if (open_valid[req_bank]) begin
                            state_reg            <= S_PRE;
                            cnt_reg              <= t_rp_reg;
                            dram_ras_n[req_bank] <= 1'b1;
                            open_valid[req_bank] <= 1'b0;
                        end else begin
                            state_reg            <= S_ACT;
                            cnt_reg              <= t_rcd_reg;
                            dram_ras_n[req_bank] <= 1'b0;
                            dram_a               <= req_row;
                        end
                    end
                end
                S_PRE: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - TW'(1);
                    end else if (ref_mode_reg) begin
                        state_reg    <= S_REF_RAS;
                        cnt_reg      <= t_ras_reg;
                        cbr_wait_reg <= CBR;
                        dram_ras_n   <= {NUM_BANKS{CBR}};
                        dram_cas_n   <= ~CBR;
                        dram_a       <= CBR ? {DA_W{1'b1}} : row_cnt;
                    end else begin
                        state_reg            <= S_ACT;
                        cnt_reg              <= t_rcd_reg;
                        dram_ras_n[cur_bank] <= 1'b0;
                        dram_a               <= cur_row;
                    end
                end
                S_ACT: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - TW'(1);
                    end else begin
                        state_reg            <= S_CAS_ON;
                        cnt_reg              <= t_cas_reg;
                        dram_cas_n           <= 1'b0;
                        dram_a               <= cur_col;
                        dram_we_n            <= ~we_reg;
                        open_valid[cur_bank] <= 1'b1;
                        open_row[cur_bank]   <= cur_row;
                    end
                end
                S_CAS_ON: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - TW'(1);
                    end else begin
                        state_reg  <= S_CAS_OFF;
                        cnt_reg    <= t_cp_reg;
                        dram_cas_n <= 1'b1;
                        dram_we_n  <= 1'b1;
                        dram_oe_n  <= 1'b1;
                        rd_le      <= ~we_reg;
                        if (!page_en_reg) begin
                            dram_ras_n[cur_bank] <= 1'b1;
                            open_valid[cur_bank] <= 1'b0;
                        end
                    end
                end
                S_CAS_OFF: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - TW'(1);
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end
                S_REF_RAS: begin
                    // CBR: CAS was dropped on entry, RAS follows one cycle later
                    if (cbr_wait_reg) begin
                        dram_ras_n   <= '0;
                        cbr_wait_reg <= 1'b0;
                    end else if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - TW'(1);
                    end else begin
                        state_reg  <= S_REF_PRE;
                        cnt_reg    <= t_rp_reg;
                        dram_ras_n <= '1;
                        dram_cas_n <= 1'b1;
                        open_valid <= '0;
                    end
                end
                S_REF_PRE: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - TW'(1);
                    end else begin
                        state_reg    <= S_IDLE;
                        ref_mode_reg <= 1'b0;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_controller_mb.sv
// Directed bench for dram_controller_mb: page-off/page-on accesses, row miss, bank isolation,
// async reset mid-access and refresh scheduling (RAS-only or CBR when DRAM_CBR_REFRESH_EN is set).
module tb_dram_controller_mb;

    logic        clk_i;
    logic        rst_n;
    logic        cfg_we;
    logic [3:0]  cfg_idx;
    logic [7:0]  cfg_data;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [19:0] req_addr;
    logic        wr_le;
    logic        rd_le;
    logic        refresh_pend;
    logic [8:0]  dram_a;
    logic [1:0]  dram_ras_n;
    logic        dram_cas_n;
    logic        dram_we_n;
    logic        dram_oe_n;

    int checks;
    int errors;

    dram_controller_mb #(
        .ADDR_W(20), .DA_W(9), .BANK_W(1), .RINT_RST(390)
    ) dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_data    (cfg_data),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .wr_le       (wr_le),
        .rd_le       (rd_le),
        .refresh_pend(refresh_pend),
        .dram_a      (dram_a),
        .dram_ras_n  (dram_ras_n),
        .dram_cas_n  (dram_cas_n),
        .dram_we_n   (dram_we_n),
        .dram_oe_n   (dram_oe_n)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [14:0] P(input logic [1:0] ras, input logic cas, input logic we,
                                      input logic oe, input logic rd, input logic [8:0] a);
        return {ras, cas, we, oe, rd, a};
    endfunction

    function automatic logic [14:0] pins();
        return {dram_ras_n, dram_cas_n, dram_we_n, dram_oe_n, rd_le, dram_a};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic step(input string tag, input logic [14:0] exp);
        check(tag, 32'(pins()), 32'(exp));
        tick();
    endtask

    task automatic cfg_write(input logic [3:0] idx, input logic [7:0] data);
        cfg_we = 1'b1;
        cfg_idx = idx;
        cfg_data = data;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic configure(input logic [7:0] mode, input logic [15:0] rint);
        for (int i = 3; i <= 7; i++) cfg_write(4'(i), 8'd1);
        cfg_write(4'd2, mode);
        cfg_write(4'd0, rint[7:0]);
        cfg_write(4'd1, rint[15:8]);
        cfg_write(4'd8, 8'd1);
    endtask

    task automatic issue(input string tag, input logic we, input logic [19:0] addr);
        req_valid = 1'b1;
        req_we = we;
        req_addr = addr;
        #1;
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_wr_le"}, 32'(wr_le), 32'(we));
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        int rd_count;
        bit found;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        cfg_we = 1'b0;
        cfg_idx = '0;
        cfg_data = '0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        tick();
        tick();
        check("reset_pins", 32'(pins()), 32'(P(2'b11, 1, 1, 1, 0, 9'h1FF)));
        check("reset_ready", 32'(req_ready), 32'd0);
        check("reset_pend", 32'(refresh_pend), 32'd0);
        rst_n = 1'b1;
        tick();
        req_valid = 1'b1;
        #1;
        check("precfg_ready", 32'(req_ready), 32'd0);
        check("precfg_wr_le", 32'(wr_le), 32'd0);
        req_valid = 1'b0;

        // Test 1: timings 1, col_bits 7, page off, read 0x00123
        configure(8'h07, 16'd390);
        $display("T1 read 0x00123 page off");
        issue("t1", 1'b0, 20'h00123);
        step("t1_act0", P(2'b10, 1, 1, 0, 0, 9'h001));
        step("t1_act1", P(2'b10, 1, 1, 0, 0, 9'h001));
        step("t1_cas0", P(2'b10, 0, 1, 0, 0, 9'h023));
        step("t1_cas1", P(2'b10, 0, 1, 0, 0, 9'h023));
        step("t1_off0", P(2'b11, 1, 1, 1, 1, 9'h023));
        step("t1_off1", P(2'b11, 1, 1, 1, 0, 9'h023));
        check("t1_ready_after", 32'(req_ready), 32'd1);

        // Test 2: page on, write 0x00100 then page-hit read 0x00155
        cfg_write(4'd2, 8'h17);
        $display("T2 write 0x00100 then read 0x00155 page on");
        issue("t2w", 1'b1, 20'h00100);
        step("t2w_act0", P(2'b10, 1, 1, 0, 0, 9'h001));
        step("t2w_act1", P(2'b10, 1, 1, 0, 0, 9'h001));
        step("t2w_cas0", P(2'b10, 0, 0, 0, 0, 9'h000));
        step("t2w_cas1", P(2'b10, 0, 0, 0, 0, 9'h000));
        step("t2w_off0", P(2'b10, 1, 1, 1, 0, 9'h000));
        step("t2w_off1", P(2'b10, 1, 1, 1, 0, 9'h000));
        issue("t2r", 1'b0, 20'h00155);
        step("t2r_cas0", P(2'b10, 0, 1, 0, 0, 9'h055));
        step("t2r_cas1", P(2'b10, 0, 1, 0, 0, 9'h055));
        step("t2r_off0", P(2'b10, 1, 1, 1, 1, 9'h055));
        step("t2r_off1", P(2'b10, 1, 1, 1, 0, 9'h055));
        check("t2_ready_after", 32'(req_ready), 32'd1);

        // Test 3: row miss on bank 0, then bank 1 access keeps bank 0 open
        $display("T3 read 0x00200 row miss, then bank1 read 0x80100");
        issue("t3a", 1'b0, 20'h00200);
        step("t3a_pre0", P(2'b11, 1, 1, 0, 0, 9'h055));
        step("t3a_pre1", P(2'b11, 1, 1, 0, 0, 9'h055));
        step("t3a_act0", P(2'b10, 1, 1, 0, 0, 9'h002));
        step("t3a_act1", P(2'b10, 1, 1, 0, 0, 9'h002));
        step("t3a_cas0", P(2'b10, 0, 1, 0, 0, 9'h000));
        step("t3a_cas1", P(2'b10, 0, 1, 0, 0, 9'h000));
        step("t3a_off0", P(2'b10, 1, 1, 1, 1, 9'h000));
        step("t3a_off1", P(2'b10, 1, 1, 1, 0, 9'h000));
        issue("t3b", 1'b0, 20'h80100);
        step("t3b_act0", P(2'b00, 1, 1, 0, 0, 9'h001));
        step("t3b_act1", P(2'b00, 1, 1, 0, 0, 9'h001));
        step("t3b_cas0", P(2'b00, 0, 1, 0, 0, 9'h000));
        step("t3b_cas1", P(2'b00, 0, 1, 0, 0, 9'h000));
        step("t3b_off0", P(2'b00, 1, 1, 1, 1, 9'h000));
        step("t3b_off1", P(2'b00, 1, 1, 1, 0, 9'h000));
        check("t3_ready_after", 32'(req_ready), 32'd1);

        // Test 4: asynchronous reset while CAS is low
        $display("T4 reset during CAS_ON");
        issue("t4", 1'b0, 20'h00200);
        check("t4_cas_on", 32'(pins()), 32'(P(2'b00, 0, 1, 0, 0, 9'h000)));
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_async_pins", 32'(pins()), 32'(P(2'b11, 1, 1, 1, 0, 9'h1FF)));
        check("t4_async_ready", 32'(req_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 20'h00123;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t4_no_rd_le_%0d", i), 32'(rd_le), 32'd0);
            check($sformatf("t4_ready_low_%0d", i), 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;

        // Test 5: refresh interval 20, request stalled by refresh
        configure(8'h07, 16'd20);
        $display("T5 refresh rint=20");
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("t5_pend_c%0d", k), 32'(refresh_pend), 32'(k == 20));
        end
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 20'h00123;
        #1;
        check("t5_stall_pend", 32'(req_ready), 32'd0);
        tick();
`ifdef DRAM_CBR_REFRESH_EN
        step("t5_cbr_cas_first", P(2'b11, 0, 1, 1, 0, 9'h1FF));
        check("t5_cbr_ras_low", 32'(pins()), 32'(P(2'b00, 0, 1, 1, 0, 9'h1FF)));
        check("t5_cbr_stall", 32'(req_ready), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (req_ready) found = 1'b1;
        end
        check("t5_ready_bound", 32'(found), 32'd1);
`else
        check("t5_ref_ras0", 32'(pins()), 32'(P(2'b00, 1, 1, 1, 0, 9'h000)));
        check("t5_stall0", 32'(req_ready), 32'd0);
        tick();
        check("t5_ref_ras1", 32'(pins()), 32'(P(2'b00, 1, 1, 1, 0, 9'h000)));
        check("t5_stall1", 32'(req_ready), 32'd0);
        tick();
        check("t5_ref_pre0", 32'(pins()), 32'(P(2'b11, 1, 1, 1, 0, 9'h000)));
        check("t5_stall2", 32'(req_ready), 32'd0);
        tick();
        check("t5_ref_pre1", 32'(dram_ras_n), 32'h3);
        check("t5_stall3", 32'(req_ready), 32'd0);
        tick();
`endif
        check("t5_ready_after_ref", 32'(req_ready), 32'd1);
        check("t5_pend_cleared", 32'(refresh_pend), 32'd0);
        tick();
        req_valid = 1'b0;
        rd_count = 0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (dram_ras_n == 2'b00) begin
                found = 1'b1;
            end else begin
                if (rd_le) rd_count++;
                tick();
            end
        end
        check("t5_second_refresh", 32'(found), 32'd1);
        check("t5_stalled_read_done", 32'(rd_count), 32'd1);
`ifdef DRAM_CBR_REFRESH_EN
        check("t5_cbr_addr", 32'(dram_a), 32'h1FF);
`else
        check("t5_row_counter", 32'(dram_a), 32'h001);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
